// File: rtl/libhdl_reset_sequencer_if.sv
// Control/status bundle of the reset sequencer: restart request and per-stage acks in, resets and status out.
// master is the sequencer side; slave is the reset-domain / software side.
interface libhdl_reset_sequencer_if #(
    parameter int NSTAGE = 4
);
    logic              i_req;
    logic [NSTAGE-1:0] i_ack;
    logic [NSTAGE-1:0] o_rst;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    modport master (
        input  i_req,
        input  i_ack,
        output o_rst,
        output o_busy,
        output o_done,
        output o_err
    );

    modport slave (
        output i_req,
        output i_ack,
        input  o_rst,
        input  o_busy,
        input  o_done,
        input  o_err
    );
endinterface

// File: rtl/libhdl_reset_sequencer.sv
// Staged reset release: hold all domains, then release them in index order, each gated by settle delay + ack.
// Latency: stage 0 releases HOLD_CYCLES edges after reset, then STAGE_DELAY+wait per stage; no backpressure, i_req restarts anytime.
module libhdl_reset_sequencer #(
    parameter int NSTAGE      = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_DELAY = 8,
    parameter int TIMEOUT     = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    libhdl_reset_sequencer_if.master bus
);

    localparam int KW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] TMO_AT    = CNT_W'(STAGE_DELAY + TIMEOUT - 1);
    localparam logic [KW-1:0]    K_LAST    = KW'(NSTAGE - 1);

    if (NSTAGE < 1) begin : g_chk_nstage
        $error("libhdl_reset_sequencer: NSTAGE must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_chk_hold_min
        $error("libhdl_reset_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (STAGE_DELAY < 1) begin : g_chk_delay_min
        $error("libhdl_reset_sequencer: STAGE_DELAY must be >= 1");
    end
    if (TIMEOUT < 0) begin : g_chk_tmo_min
        $error("libhdl_reset_sequencer: TIMEOUT must be >= 0");
    end
    if (longint'(HOLD_CYCLES) >= (longint'(1) << CNT_W)) begin : g_chk_hold_w
        $error("libhdl_reset_sequencer: HOLD_CYCLES does not fit in CNT_W");
    end
    if ((longint'(STAGE_DELAY) + longint'(TIMEOUT)) >= (longint'(1) << CNT_W)) begin : g_chk_tmo_w
        $error("libhdl_reset_sequencer: STAGE_DELAY+TIMEOUT does not fit in CNT_W");
    end

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_SETTLE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [KW-1:0]     k_q,     k_d;
    logic [NSTAGE-1:0] rst_q,   rst_d;
    logic              err_q,   err_d;
    logic              ack_sel;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            k_q     <= '0;
            rst_q   <= '1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            rst_q   <= rst_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        rst_d   = rst_q;
        err_d   = err_q;
        ack_sel = 1'b0;

        for (int i = 0; i < NSTAGE; i++) begin
            if (i == int'(k_q)) begin
                ack_sel = bus.i_ack[i];
            end
        end

        if (bus.i_req) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            k_d     = '0;
            rst_d   = '1;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == HOLD_LAST) begin
                        rst_d[0] = 1'b0;
                        state_d  = ST_SETTLE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_SETTLE, ST_WAIT: begin
                    if ((state_q == ST_SETTLE) && (cnt_q != SAMPLE_AT)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (ack_sel) begin
                        cnt_d = '0;
                        if (k_q == K_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            k_d     = k_q + KW'(1);
                            state_d = ST_SETTLE;
                            for (int i = 0; i < NSTAGE; i++) begin
                                if (i == int'(k_q) + 1) begin
                                    rst_d[i] = 1'b0;
                                end
                            end
                        end
                    end else if ((state_q == ST_WAIT) && (TIMEOUT != 0) && (cnt_q == TMO_AT)) begin
                        // Full retry from the hold phase; the error stays until i_req or reset.
                        err_d   = 1'b1;
                        rst_d   = '1;
                        state_d = ST_ASSERT;
                        cnt_d   = '0;
                        k_d     = '0;
                    end else begin
                        state_d = ST_WAIT;
                        // With no timeout the counter parks instead of wrapping.
                        if (!((state_q == ST_WAIT) && (TIMEOUT == 0))) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end

                ST_DONE: begin
                    state_d = ST_DONE;
                end

                default: begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    k_d     = '0;
                    rst_d   = '1;
                end
            endcase
        end
    end

    assign bus.o_rst  = rst_q;
    assign bus.o_busy = (state_q != ST_DONE);
    assign bus.o_done = (state_q == ST_DONE);
    assign bus.o_err  = err_q;

endmodule

// File: tb/tb_libhdl_reset_sequencer.sv
// Bench for libhdl_reset_sequencer: directed timing scenarios plus random acks/requests/resets
// against an edge-timestamp reference model, on two instances (TIMEOUT=5 and TIMEOUT=0).
module tb_libhdl_reset_sequencer;

    localparam int NST  = 3;
    localparam int HOLD = 4;
    localparam int DLY  = 2;
    localparam int TMO  = 5;

    logic i_clk;
    logic i_rst_n;

    int n_cmp;
    int n_bad;
    int edge_n;

    libhdl_reset_sequencer_if #(.NSTAGE(NST)) bus_a ();
    libhdl_reset_sequencer_if #(.NSTAGE(NST)) bus_b ();

    libhdl_reset_sequencer #(
        .NSTAGE(NST), .HOLD_CYCLES(HOLD), .STAGE_DELAY(DLY), .TIMEOUT(TMO), .CNT_W(16)
    ) u_dut_a (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus_a.master)
    );

    libhdl_reset_sequencer #(
        .NSTAGE(NST), .HOLD_CYCLES(HOLD), .STAGE_DELAY(DLY), .TIMEOUT(0), .CNT_W(16)
    ) u_dut_b (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus_b.master)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference model: index 0 tracks instance a, index 1 instance b.
    // m_k = -1 means no stage released yet; m_start is the edge the hold phase counts from,
    // m_rel the edge on which stage m_k was released.
    logic [NST-1:0] m_rst [2];
    logic           m_err [2];
    logic           m_done[2];
    int             m_k   [2];
    int             m_start[2];
    int             m_rel [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h, want %0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic model_restart(input int u, input int at_edge);
        m_rst[u]   = '1;
        m_done[u]  = 1'b0;
        m_k[u]     = -1;
        m_start[u] = at_edge;
        m_rel[u]   = 0;
    endtask

    task automatic model_step(input int u, input bit req, input logic [NST-1:0] ack, input int tmo);
        if (req) begin
            model_restart(u, edge_n);
            m_err[u] = 1'b0;
        end else if (m_done[u]) begin
            m_done[u] = 1'b1;
        end else if (m_k[u] < 0) begin
            if (edge_n == m_start[u] + HOLD) begin
                m_rst[u][0] = 1'b0;
                m_k[u]      = 0;
                m_rel[u]    = edge_n;
            end
        end else if (edge_n >= m_rel[u] + DLY) begin
            if (ack[m_k[u]]) begin
                if (m_k[u] == NST - 1) begin
                    m_done[u] = 1'b1;
                end else begin
                    m_k[u]             = m_k[u] + 1;
                    m_rst[u][m_k[u]]   = 1'b0;
                    m_rel[u]           = edge_n;
                end
            end else if (tmo > 0 && edge_n == m_rel[u] + DLY + tmo) begin
                m_err[u] = 1'b1;
                model_restart(u, edge_n);
            end
        end
    endtask

    function automatic logic [31:0] model_vec(input int u);
        return {26'd0, m_rst[u], ~m_done[u], m_done[u], m_err[u]};
    endfunction

    task automatic tick(input bit req, input logic [NST-1:0] ack_a, input logic [NST-1:0] ack_b);
        bus_a.i_req = req;
        bus_a.i_ack = ack_a;
        bus_b.i_req = req;
        bus_b.i_ack = ack_b;
        @(posedge i_clk);
        edge_n++;
        model_step(0, req, ack_a, TMO);
        model_step(1, req, ack_b, 0);
        #1;
        chk("model_a", {26'd0, bus_a.o_rst, bus_a.o_busy, bus_a.o_done, bus_a.o_err}, model_vec(0));
        chk("model_b", {26'd0, bus_b.o_rst, bus_b.o_busy, bus_b.o_done, bus_b.o_err}, model_vec(1));
        bus_a.i_req = 1'b0;
        bus_b.i_req = 1'b0;
    endtask

    task automatic run_to(input int target, input logic [NST-1:0] ack_a);
        while (edge_n < target) tick(1'b0, ack_a, 3'b111);
    endtask

    // Asserts reset between edges, checks the outputs before any clock edge, then releases.
    task automatic do_reset(input string tag);
        i_rst_n = 1'b0;
        #1;
        chk({tag, "_rst"},  {29'd0, bus_a.o_rst}, 32'h7);
        chk({tag, "_busy"}, {31'd0, bus_a.o_busy}, 32'h1);
        chk({tag, "_done"}, {31'd0, bus_a.o_done}, 32'h0);
        chk({tag, "_err"},  {31'd0, bus_a.o_err},  32'h0);
        chk({tag, "_b"},    {26'd0, bus_b.o_rst, bus_b.o_busy, bus_b.o_done, bus_b.o_err}, 32'h3C);
        edge_n = 0;
        model_restart(0, 0);
        model_restart(1, 0);
        m_err[0] = 1'b0;
        m_err[1] = 1'b0;
        #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        edge_n = 0;
        i_rst_n = 1'b0;
        bus_a.i_req = 1'b0;
        bus_a.i_ack = '0;
        bus_b.i_req = 1'b0;
        bus_b.i_ack = '0;
        repeat (2) @(posedge i_clk);
        #1;
        do_reset("init");

        // Acks tied high.
        run_to(3, 3'b111);   chk("s1_e3",  {29'd0, bus_a.o_rst}, 32'h7);
        run_to(4, 3'b111);   chk("s1_e4",  {29'd0, bus_a.o_rst}, 32'h6);
        run_to(5, 3'b111);   chk("s1_e5",  {29'd0, bus_a.o_rst}, 32'h6);
        run_to(6, 3'b111);   chk("s1_e6",  {29'd0, bus_a.o_rst}, 32'h4);
        run_to(8, 3'b111);   chk("s1_e8",  {29'd0, bus_a.o_rst}, 32'h0);
        run_to(9, 3'b111);   chk("s1_e9",  {31'd0, bus_a.o_done}, 32'h0);
        run_to(10, 3'b111);
        chk("s1_done", {30'd0, bus_a.o_done, bus_a.o_busy}, 32'h2);
        chk("s1_err",  {31'd0, bus_a.o_err}, 32'h0);

        // Restart request while done.
        run_to(19, 3'b111);
        tick(1'b1, 3'b111, 3'b111);
        chk("s4_e20", {26'd0, bus_a.o_rst, bus_a.o_busy, bus_a.o_done, bus_a.o_err}, 32'h3C);
        run_to(23, 3'b111);  chk("s4_e23", {29'd0, bus_a.o_rst}, 32'h7);
        run_to(24, 3'b111);  chk("s4_e24", {29'd0, bus_a.o_rst}, 32'h6);

        // Ack of stage 1 arrives late, sampled at edge 12.
        do_reset("s2");
        run_to(11, 3'b101);  chk("s2_e11", {29'd0, bus_a.o_rst}, 32'h4);
        run_to(12, 3'b111);  chk("s2_e12", {29'd0, bus_a.o_rst}, 32'h0);
        run_to(13, 3'b111);  chk("s2_e13", {31'd0, bus_a.o_done}, 32'h0);
        run_to(14, 3'b111);
        chk("s2_done", {31'd0, bus_a.o_done}, 32'h1);
        chk("s2_err",  {31'd0, bus_a.o_err},  32'h0);

        // Ack of stage 1 never arrives: timeout and retry.
        do_reset("s3");
        run_to(12, 3'b101);
        chk("s3_e12", {29'd0, bus_a.o_rst, bus_a.o_err}, 32'h8);
        run_to(13, 3'b101);
        chk("s3_e13", {29'd0, bus_a.o_rst, bus_a.o_err}, 32'hF);
        run_to(16, 3'b101);  chk("s3_e16", {29'd0, bus_a.o_rst}, 32'h7);
        run_to(17, 3'b101);
        chk("s3_e17", {29'd0, bus_a.o_rst, bus_a.o_err}, 32'hD);
        tick(1'b1, 3'b101, 3'b111);
        chk("s3_req_clr", {31'd0, bus_a.o_err}, 32'h0);

        // Timeout error is cleared by reset; mid-sequence reset restarts timing from edge 1.
        do_reset("s5a");
        run_to(13, 3'b101);
        chk("s5_err_set", {31'd0, bus_a.o_err}, 32'h1);
        do_reset("s5b");
        run_to(7, 3'b111);
        do_reset("s5c");
        run_to(3, 3'b111);   chk("s5_e3", {29'd0, bus_a.o_rst}, 32'h7);
        run_to(4, 3'b111);   chk("s5_e4", {29'd0, bus_a.o_rst}, 32'h6);

        // Instance b waits forever for the last ack.
        do_reset("s6");
        for (int i = 0; i < 1000; i++) tick(1'b0, 3'b111, 3'b011);
        chk("s6_hold", {26'd0, bus_b.o_rst, bus_b.o_busy, bus_b.o_done, bus_b.o_err}, 32'h04);
        tick(1'b0, 3'b111, 3'b111);
        chk("s6_done", {31'd0, bus_b.o_done}, 32'h1);

        // Random acks, restart requests and occasional resets.
        do_reset("rnd");
        for (int i = 0; i < 4000; i++) begin
            int unsigned r;
            r = $urandom_range(0, 999);
            if (r < 3) begin
                @(negedge i_clk);
                do_reset("rnd_mid");
            end else begin
                tick(r < 10, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/libhdl_reset_sequencer.md
# libhdl_reset_sequencer

Staged reset release controller sitting directly downstream of the reset synchronizer. Its reset input is the synchronized reset from that stage. It holds all reset domains in reset for a minimum time, then releases them one at a time in index order. Each release waits a fixed settle delay plus a per-stage ready acknowledge (PLL lock, memory init done, etc.), with an optional timeout and automatic retry. A synchronous software request re-runs the whole sequence.

## Interface
- NSTAGE, 4: number of reset domains; must be ≥ 1.
- HOLD_CYCLES, 16: cycles all resets are held after entering the assert phase; must be ≥ 1.
- STAGE_DELAY, 8: settle cycles after releasing a stage before its ack is sampled; must be ≥ 1.
- TIMEOUT, 1024: cycles allowed for an ack after STAGE_DELAY; 0 = wait forever.
- CNT_W, 16: counter width; elaboration error if any of HOLD_CYCLES, STAGE_DELAY+TIMEOUT ≥ 2^CNT_W.
- i_clk  input  1  single clock; all logic on its rising edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low; deassertion already synchronous to i_clk.
- i_req  input  1  synchronous single-cycle restart request, active-high.
- i_ack  input  NSTAGE  per-stage ready, synchronous to i_clk, active-high.
- o_rst  output  NSTAGE  per-domain reset, active-high; driven directly from flops.
- o_busy  output  1  high while not in DONE.
- o_done  output  1  high in DONE.
- o_err  output  1  sticky ack-timeout flag.

## Operation
- States: ASSERT, SETTLE(k), WAIT_ACK(k), DONE; k = current stage index, 0..NSTAGE-1.
- Async reset (i_rst_n=0) drives the block immediately, without a clock edge:
  - state ASSERT, counter 0, k 0;
  - o_rst all ones, o_busy 1, o_done 0, o_err 0.
- ASSERT:
  - counter increments each edge;
  - on the edge where counter == HOLD_CYCLES-1: o_rst[0] clears, go to SETTLE(0), counter 0.
- SETTLE(k):
  - counter counts STAGE_DELAY cycles;
  - on the edge where counter == STAGE_DELAY-1, i_ack[k] is sampled.
- Ack handling, from that edge onward:
  - If i_ack[k]=1 and k<NSTAGE-1: o_rst[k+1] clears on the same edge, go to SETTLE(k+1).
  - If i_ack[k]=1 and k=NSTAGE-1: go to DONE on the same edge; o_done 1, o_busy 0.
  - If i_ack[k]=0: go to WAIT_ACK(k) and sample i_ack[k] each subsequent edge with the same rules.
- Timeout (TIMEOUT>0):
  - if i_ack[k] has not been seen by the edge TIMEOUT cycles after the SETTLE sample edge, that edge sets o_err=1;
  - the same edge returns all o_rst to 1 and enters ASSERT (full retry, counter 0, k 0).
- Released stages never re-assert except via ASSERT; o_rst bits are only ever cleared in index order.
- Acks of already-released stages are not monitored; in DONE, i_ack is ignored.
- i_req=1 in any state:
  - next edge: ASSERT, counter 0, k 0, all o_rst 1, o_done 0, o_busy 1, o_err 0;
  - i_req takes priority over timeout and ack on the same edge.
- An unreleased stage's i_ack being high early has no effect.

## Timing
- Edges are counted from the first rising edge with i_rst_n=1 (edge 1). Let E_k = edge on which o_rst[k] clears, and D = STAGE_DELAY.
- E_0 = HOLD_CYCLES.
- E_{k+1} = E_k + D + w_k, where w_k ≥ 0 = extra cycles until i_ack[k] is sampled high.
- o_done rises on edge E_{NSTAGE-1} + D + w_{NSTAGE-1}.
- Timeout edge for stage k = E_k + D + TIMEOUT, if no ack has been sampled by then.
- Async reset mid-sequence: all outputs return to reset values combinationally from the flop reset; the sequence restarts from ASSERT after release.

## Test plan
- Setup: NSTAGE=3, HOLD_CYCLES=4, STAGE_DELAY=2, TIMEOUT=5.
- Acks tied high -> o_rst[0] falls edge 4, o_rst[1] edge 6, o_rst[2] edge 8; o_done=1 and o_busy=0 at edge 10; o_err stays 0.
- i_ack[1] low until sampled high at edge 12 -> o_rst[2] falls edge 12, o_done at edge 14, o_err 0.
- i_ack[1] held low -> edge 13 sets o_err=1 and o_rst=3'b111; o_rst[0] falls again at edge 17; o_err stays 1 until i_req or reset.
- i_req pulse while in DONE at edge 20 -> edge 20 gives o_rst=3'b111, o_done 0, o_busy 1, o_err 0; o_rst[0] falls edge 24.
- i_rst_n driven low between edges 7 and 8 -> o_rst=3'b111, o_done 0, o_err 0 before any further clock edge; after release, timing repeats from edge 1.
- TIMEOUT=0 with i_ack[2] low for 1000 cycles -> no o_err, o_rst stays 3'b000, o_busy 1; o_done rises on the edge i_ack[2] is sampled high.
